// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
//
// Takes a little-endian byte stream, packs it into WIDTH-bit instruction
// words, and writes each word to instruction memory at
// BASE_ADDR + 4*word_index. The CPU is held in reset (cpu_rst=1) until a
// load finishes without being rejected.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, accepted in IDLE or DONE only
//   len[15:0]    word count, sampled on an accepted start
//   byte_valid   byte_data is valid
//   byte_data    program byte stream
//   byte_ready   a byte is taken when byte_valid && byte_ready
//   mem_we       one-cycle write strobe per assembled word
//   mem_addr     word-aligned byte address of the write
//   mem_wdata    assembled instruction word
//   cpu_rst      core reset hold, released only after a clean load
//   busy         load in progress
//   done         last load completed (sticky until next start)
//   err          last start rejected for len > DEPTH (sticky)
module imem_loader #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] part;
  logic        err_q;

  logic        start_ok;
  logic        len_zero;
  logic        len_over;
  logic        byte_take;
  logic        last_word;
  logic [WIDTH-1:0] word_off;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign len_zero  = (len == 16'd0);
  assign len_over  = ({1'b0, len} > 17'(DEPTH));
  assign byte_take = byte_valid && (state == ASSEMBLE);
  // len_q >= 1 whenever this is consulted (only in WRITE).
  assign last_word = (word_idx == (len_q - 16'd1));
  assign word_off  = WIDTH'({word_idx, 2'b00});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_rst    = 1'b1;
    err        = err_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len_zero || len_over) ? DONE : ASSEMBLE;
      end
      ASSEMBLE: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        state_nxt = last_word ? DONE : ASSEMBLE;
      end
      DONE: begin
        done    = 1'b1;
        // A rejected load leaves no valid program, so the core stays held.
        cpu_rst = err_q;
        if (start) state_nxt = (len_zero || len_over) ? DONE : ASSEMBLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      part      <= '0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= len;
        word_idx <= '0;
        byte_cnt <= '0;
        err_q    <= len_over;
      end
      if (byte_take) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: part[7:0]   <= byte_data;
          2'd1: part[15:8]  <= byte_data;
          2'd2: part[23:16] <= byte_data;
          default: begin
            // Fourth byte completes the word: present it for the WRITE cycle.
            mem_wdata <= WIDTH'({byte_data, part});
            mem_addr  <= BASE_ADDR + word_off;
          end
        endcase
      end
      if ((state == WRITE) && !last_word) begin
        word_idx <= word_idx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      len;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             cpu_rst;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: the program bytes of the current load and the
  // writes they must produce, plus a log of what the DUT actually wrote.
  logic [7:0]  stream[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] last_addr;
  logic [31:0] last_data;
  logic        exp_err;
  int          pulse_cycle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Every write a load of L words must make, derived from the byte stream.
  task automatic set_expect(input int L);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_err = (L > DEPTH);
    if (L >= 1 && L <= DEPTH) begin
      for (int i = 0; i < L; i++) begin
        exp_addr_q.push_back(32'(4 * i));
        exp_data_q.push_back({stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
      end
    end
  endtask

  task automatic fill_random(input int L);
    stream.delete();
    for (int i = 0; i < 4 * L; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int L);
    got_addr.delete();
    got_data.delete();
    len   = 16'(L);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present the first n bytes of the stream with random valid gaps.
  task automatic feed(input int n);
    int idx = 0;
    int cyc = 0;
    logic hs;
    while (idx < n && cyc < 20 * n + 20) begin
      if (cyc == pulse_cycle) begin
        start = 1'b1;
        len   = 16'd1;
      end else begin
        start = 1'b0;
      end
      byte_valid = ($urandom_range(0, 3) != 0);
      byte_data  = byte_valid ? stream[idx] : 8'($urandom_range(0, 255));
      @(negedge clk);
      hs = byte_valid && byte_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    pulse_cycle = -1;
    if (idx < n) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: consumed %0d bytes, required %0d", idx, n);
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("err_after", 32'(err), 32'(exp_err));
    check("cpu_rst_after", 32'(cpu_rst), 32'(exp_err));
    check("writes_left", 32'(exp_addr_q.size()), 32'd0);
  endtask

  // Compare process: every write must match the model in order, and the
  // address/data outputs must hold between writes.
  always @(negedge clk) begin
    if (!rst) begin
      last_addr = '0;
      last_data = '0;
    end else if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", mem_addr, mem_wdata);
      end else begin
        check("write_addr", mem_addr, exp_addr_q.pop_front());
        check("write_data", mem_wdata, exp_data_q.pop_front());
      end
      check("ready_in_write", 32'(byte_ready), 32'd0);
      last_addr = mem_addr;
      last_data = mem_wdata;
    end else begin
      check("hold_addr", mem_addr, last_addr);
      check("hold_data", mem_wdata, last_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
    pulse_cycle = -1; exp_err = 1'b0;
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("idle_done", 32'(done), 32'd0);

    // Single word; junk bytes offered in IDLE must not be consumed.
    byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_data = 8'($urandom_range(0, 255));
      tick();
    end
    byte_valid = 1'b0;
    stream = '{8'h13, 8'h00, 8'h00, 8'h00};
    set_expect(1);
    do_start(1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    feed(4);
    wait_done();
    check("lit1_count", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() == 1) begin
      check("lit1_addr", got_addr[0], 32'h0);
      check("lit1_data", got_data[0], 32'h0000_0013);
    end

    // Two words with valid gaps.
    stream = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h10, 8'h00};
    set_expect(2);
    do_start(2);
    feed(8);
    wait_done();
    check("lit2_count", 32'(got_addr.size()), 32'd2);
    if (got_addr.size() == 2) begin
      check("lit2_addr0", got_addr[0], 32'h0);
      check("lit2_data0", got_data[0], 32'h0010_0093);
      check("lit2_addr1", got_addr[1], 32'h4);
      check("lit2_data1", got_data[1], 32'h0010_80B3);
    end

    // Zero-length load.
    set_expect(0);
    do_start(0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_cpu_rst", 32'(cpu_rst), 32'd0);
    check("len0_err", 32'(err), 32'd0);
    tick(); tick();
    check("len0_busy", 32'(busy), 32'd0);

    // Oversize load is rejected.
    set_expect(DEPTH + 1);
    do_start(DEPTH + 1);
    check("over_err", 32'(err), 32'd1);
    check("over_done", 32'(done), 32'd1);
    check("over_cpu_rst", 32'(cpu_rst), 32'd1);
    tick(); tick(); tick();
    check("over_cpu_rst_held", 32'(cpu_rst), 32'd1);

    // Reset mid-word discards the partial word.
    stream = '{8'h11, 8'h22, 8'h33, 8'h44};
    set_expect(1);
    do_start(1);
    feed(2);
    #2;
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    #1;
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    check("postrst_busy", 32'(busy), 32'd0);
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    set_expect(1);
    do_start(1);
    feed(4);
    wait_done();
    check("lit3_count", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() == 1) begin
      check("lit3_addr", got_addr[0], 32'h0);
      check("lit3_data", got_data[0], 32'hDDCC_BBAA);
    end

    // Start pulsed mid-load is ignored; the load keeps its 3 words.
    fill_random(3);
    set_expect(3);
    do_start(3);
    pulse_cycle = 3;
    feed(12);
    wait_done();
    check("ignored_start_count", 32'(got_addr.size()), 32'd3);

    // Restart from DONE re-asserts cpu_rst and begins at the base address.
    fill_random(2);
    set_expect(2);
    do_start(2);
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    feed(8);
    wait_done();
    if (got_addr.size() > 0) check("restart_addr0", got_addr[0], 32'h0);

    // Randomised loads.
    for (int t = 0; t < 6; t++) begin
      int L = $urandom_range(1, 6);
      fill_random(L);
      set_expect(L);
      do_start(L);
      pulse_cycle = $urandom_range(0, 8);
      feed(4 * L);
      wait_done();
    end

    // Full-capacity load.
    fill_random(DEPTH);
    set_expect(DEPTH);
    do_start(DEPTH);
    feed(4 * DEPTH);
    wait_done();
    check("full_count", 32'(got_addr.size()), 32'(DEPTH));
    if (got_addr.size() == DEPTH) check("full_last_addr", got_addr[DEPTH-1], 32'(4 * (DEPTH - 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
